// File: rtl/normalizador_pipe.sv
// normalizador_pipe: three-stage FP normaliser / rounder / packer.
// S1 selects the add or multiply path and counts leading zeros. S2 shifts and extracts G/R/S.
// S3 rounds, detects overflow/underflow and packs the result.
// A single advance enable stalls every stage when the output is blocked.
module normalizador_pipe #(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int PROD_W = 2*(MAN_W+1),
  parameter int SUM_W  = MAN_W+4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   OP_input,
  input  logic                   Signo_mul,
  input  logic                   Signo_sum,
  input  logic [EXP_W-1:0]       Exp_comun,
  input  logic [EXP_W:0]         Exp_resul,
  input  logic [PROD_W-1:0]      Producto,
  input  logic [SUM_W-1:0]       Suma_resul,
  input  logic [1:0]             rnd_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   Resultado,
  output logic                   flag_ovf,
  output logic                   flag_unf,
  output logic                   flag_inx,
  output logic                   flag_zero
);

  localparam int DW   = PROD_W;
  localparam int LZ_W = $clog2(DW);
  localparam int EW   = EXP_W + 2;
  localparam int XW   = EXP_W + 3;
  localparam logic signed [XW-1:0] X_SAT = XW'((1 << (EW-1)) - 1);
  localparam logic signed [XW-1:0] X_OVF = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] X_ONE = XW'(1);
  localparam logic [EXP_W-1:0]     E_MAXFIN = EXP_W'((1 << EXP_W) - 2);

  typedef enum logic [1:0] {RM_RNE = 2'd0, RM_RTZ = 2'd1, RM_RUP = 2'd2, RM_RDN = 2'd3} rnd_e;

  logic w_en;

  // Stage 1 registers
  logic                 r1_valid;
  logic [DW-1:0]        r1_data;
  logic [LZ_W-1:0]      r1_lz;
  logic signed [EW-1:0] r1_exp;
  logic                 r1_sign;
  rnd_e                 r1_rnd;

  // Stage 2 registers
  logic                 r2_valid;
  logic [MAN_W-1:0]     r2_frac;
  logic                 r2_g, r2_r, r2_s;
  logic signed [EW-1:0] r2_exp;
  logic                 r2_sign;
  logic                 r2_zero;
  rnd_e                 r2_rnd;

  // Stage 3 (output) registers
  logic                 r3_valid;
  logic [EXP_W+MAN_W:0] r_res;
  logic                 r_ovf, r_unf, r_inx, r_zero;

  // Stage 1 combinational signals
  logic [DW-1:0]        w_data;
  logic signed [XW-1:0] w_base;
  logic [LZ_W-1:0]      w_lz;
  logic signed [XW-1:0] w_exp1;
  logic signed [XW-1:0] w_exp1_sat;

  // Stage 2 combinational signals
  logic [DW-1:0]        w_v;

  // Stage 3 combinational signals
  logic                 w_inc;
  logic                 w_grs;
  logic [MAN_W:0]       w_fsum;
  logic signed [XW-1:0] w_exp_r;
  logic                 w_ovf_c, w_unf_c, w_to_inf;
  logic [EXP_W+MAN_W:0] w_res;
  logic                 w_ovf, w_unf, w_inx, w_zero;

  assign w_en      = ~r3_valid | out_ready;
  assign in_ready  = w_en;
  assign out_valid = r3_valid;
  assign Resultado = r_res;
  assign flag_ovf  = r_ovf;
  assign flag_unf  = r_unf;
  assign flag_inx  = r_inx;
  assign flag_zero = r_zero;

  // S1: left-align the selected mantissa so that both paths share one carry/hidden position,
  //     then compute the exact leading-zero count and the adjusted exponent.
  always_comb begin
    w_data = OP_input ? Producto : (DW'(Suma_resul) << (DW - SUM_W));
    w_base = OP_input ? {{(XW-EXP_W-1){1'b0}}, Exp_resul} : {{(XW-EXP_W){1'b0}}, Exp_comun};
    w_lz   = '0;
    for (int unsigned i = 0; i < DW-1; i++) begin
      if (w_data[i]) w_lz = LZ_W'(DW - 2 - i);
    end
    if (w_data[DW-1]) w_exp1 = w_base + X_ONE;
    else              w_exp1 = w_base - {{(XW-LZ_W){1'b0}}, w_lz};
    w_exp1_sat = (w_exp1 > X_SAT) ? X_SAT : w_exp1;
  end

  // S1 register: capture path data, shift count, exponent, sign and rounding mode
  always_ff @(posedge clk) begin
    if (rst) begin
      r1_valid <= 1'b0;
    end else if (w_en) begin
      r1_valid <= in_valid;
      r1_data  <= w_data;
      r1_lz    <= w_lz;
      r1_exp   <= w_exp1_sat[EW-1:0];
      r1_sign  <= OP_input ? Signo_mul : Signo_sum;
      r1_rnd   <= rnd_e'(rnd_mode);
    end
  end

  // S2: place the hidden bit at the top of w_v; a right-normalise keeps the data unshifted
  always_comb begin
    if (r1_data[DW-1]) w_v = r1_data;
    else               w_v = {r1_data[DW-2:0], 1'b0} << r1_lz;
  end

  // S2 register: fraction plus guard/round/sticky.
  // After normalisation the hidden bit is clear only for an all-zero input, so it doubles as the zero flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r2_valid <= 1'b0;
    end else if (w_en) begin
      r2_valid <= r1_valid;
      r2_frac  <= w_v[DW-2 -: MAN_W];
      r2_g     <= w_v[DW-MAN_W-2];
      r2_r     <= w_v[DW-MAN_W-3];
      r2_s     <= |w_v[DW-MAN_W-4:0];
      r2_exp   <= r1_exp;
      r2_sign  <= r1_sign;
      r2_zero  <= ~w_v[DW-1];
      r2_rnd   <= r1_rnd;
    end
  end

  // S3: rounding decision, renormalisation on carry, exception detection and packing.
  // The hidden bit is implicitly 1 here, so a carry out of the fraction means mantissa 2.0 -> 1.0, exp+1.
  always_comb begin
    w_grs = r2_g | r2_r | r2_s;
    case (r2_rnd)
      RM_RNE:  w_inc = r2_g & (r2_r | r2_s | r2_frac[0]);
      RM_RTZ:  w_inc = 1'b0;
      RM_RUP:  w_inc = w_grs & ~r2_sign;
      default: w_inc = w_grs & r2_sign;
    endcase
    w_fsum   = {1'b0, r2_frac} + {{MAN_W{1'b0}}, w_inc};
    w_exp_r  = {{(XW-EW){r2_exp[EW-1]}}, r2_exp} + {{(XW-1){1'b0}}, w_fsum[MAN_W]};
    w_ovf_c  = (w_exp_r >= X_OVF);
    w_unf_c  = (w_exp_r <= 0);
    w_to_inf = (r2_rnd == RM_RNE) | ((r2_rnd == RM_RUP) & ~r2_sign) | ((r2_rnd == RM_RDN) & r2_sign);
    w_res  = '0;
    w_ovf  = 1'b0;
    w_unf  = 1'b0;
    w_inx  = 1'b0;
    w_zero = 1'b0;
    if (r2_zero) begin
      w_res  = {r2_sign, {(EXP_W+MAN_W){1'b0}}};
      w_zero = 1'b1;
    end else if (w_ovf_c) begin
      w_res = w_to_inf ? {r2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                       : {r2_sign, E_MAXFIN, {MAN_W{1'b1}}};
      w_ovf = 1'b1;
      w_inx = 1'b1;
    end else if (w_unf_c) begin
      w_res = {r2_sign, {(EXP_W+MAN_W){1'b0}}};
      w_unf = 1'b1;
      w_inx = 1'b1;
    end else begin
      w_res = {r2_sign, w_exp_r[EXP_W-1:0], w_fsum[MAN_W-1:0]};
      w_inx = w_grs;
    end
  end

  // S3 register: output result and flags, held while downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      r3_valid <= 1'b0;
      r_res    <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_inx    <= 1'b0;
      r_zero   <= 1'b0;
    end else if (w_en) begin
      r3_valid <= r2_valid;
      r_res    <= w_res;
      r_ovf    <= w_ovf;
      r_unf    <= w_unf;
      r_inx    <= w_inx;
      r_zero   <= w_zero;
    end
  end

endmodule

// File: tb/tb_normalizador_pipe.sv
// tb_normalizador_pipe: directed stimulus with a scoreboard queue of expected results.
module tb_normalizador_pipe;

  localparam logic [1:0] RNE = 2'd0, RTZ = 2'd1, RUP = 2'd2, RDN = 2'd3;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, OP_input, Signo_mul, Signo_sum;
  logic [7:0]  Exp_comun;
  logic [8:0]  Exp_resul;
  logic [47:0] Producto;
  logic [26:0] Suma_resul;
  logic [1:0]  rnd_mode;
  logic        out_valid, out_ready;
  logic [31:0] Resultado;
  logic        flag_ovf, flag_unf, flag_inx, flag_zero;
  logic [35:0] w_obs;

  typedef struct { logic [35:0] exp; int acc; } item_t;
  item_t q[$];

  int   nassert = 0, nfail = 0, ncyc = 0;
  bit   chk_lat = 1'b1, saw_stall = 1'b0, stalled_prev = 1'b0;
  logic [35:0] prev_out;

  normalizador_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .OP_input(OP_input), .Signo_mul(Signo_mul), .Signo_sum(Signo_sum),
    .Exp_comun(Exp_comun), .Exp_resul(Exp_resul), .Producto(Producto),
    .Suma_resul(Suma_resul), .rnd_mode(rnd_mode), .out_valid(out_valid),
    .out_ready(out_ready), .Resultado(Resultado), .flag_ovf(flag_ovf),
    .flag_unf(flag_unf), .flag_inx(flag_inx), .flag_zero(flag_zero)
  );

  assign w_obs = {Resultado, flag_ovf, flag_unf, flag_inx, flag_zero};

  always #5 clk = ~clk;
  always @(posedge clk) ncyc++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: stall behaviour, then in-order scoreboard compare with latency
  always @(negedge clk) begin : mon
    item_t e;
    if (rst) begin
      stalled_prev = 1'b0;
    end else begin
      if (out_valid && !out_ready) begin
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        if (stalled_prev) chk("stall_hold", 64'(w_obs), 64'(prev_out));
        saw_stall    = 1'b1;
        stalled_prev = 1'b1;
        prev_out     = w_obs;
      end else begin
        stalled_prev = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", 64'(out_valid), 64'd0);
        end else begin
          e = q.pop_front();
          chk("result_flags", 64'(w_obs), 64'(e.exp));
          if (chk_lat) chk("latency", 64'(ncyc - e.acc), 64'd3);
        end
      end
    end
  end

  task automatic send(input logic op, input logic sgn, input logic [7:0] ec, input logic [8:0] er,
                      input logic [47:0] prod, input logic [26:0] sum, input logic [1:0] rm,
                      input logic [31:0] eres, input logic [3:0] eflg);
    int t;
    item_t e;
    OP_input   = op;
    Signo_mul  = op ? sgn : ~sgn;
    Signo_sum  = op ? ~sgn : sgn;
    Exp_comun  = op ? 8'hA5 : ec;
    Exp_resul  = op ? er : 9'h05A;
    Producto   = op ? prod : 48'h123456789ABC;
    Suma_resul = op ? 27'h5A5A5A5 : sum;
    rnd_mode   = rm;
    in_valid   = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
    else begin
      e.exp = {eres, eflg};
      e.acc = ncyc;
      q.push_back(e);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    chk("drain", 64'(q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; OP_input = 1'b0;
    Signo_mul = 1'b0; Signo_sum = 1'b0; Exp_comun = '0; Exp_resul = '0;
    Producto = '0; Suma_resul = '0; rnd_mode = RNE;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(Resultado), 64'd0);
    chk("rst_flags", 64'({flag_ovf, flag_unf, flag_inx, flag_zero}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 out_ready = 1'b1;

    // Basic multiply/add paths
    send(1, 0, 8'd0,   9'd127, 48'h900000000000, 27'h0,       RNE, 32'h40100000, 4'b0000);
    send(0, 0, 8'd127, 9'd0,   48'h0,            27'h2000000, RNE, 32'h3F800000, 4'b0000);
    send(0, 0, 8'd127, 9'd0,   48'h0,            27'h4000000, RNE, 32'h40000000, 4'b0000);
    // Tie rounding, positive and negative, all modes
    send(0, 0, 8'd127, 9'd0, 48'h0, 27'h2000002, RNE, 32'h3F800000, 4'b0010);
    send(0, 0, 8'd127, 9'd0, 48'h0, 27'h2000002, RTZ, 32'h3F800000, 4'b0010);
    send(0, 0, 8'd127, 9'd0, 48'h0, 27'h2000002, RUP, 32'h3F800001, 4'b0010);
    send(0, 0, 8'd127, 9'd0, 48'h0, 27'h2000002, RDN, 32'h3F800000, 4'b0010);
    send(0, 1, 8'd127, 9'd0, 48'h0, 27'h2000002, RDN, 32'hBF800001, 4'b0010);
    send(0, 1, 8'd127, 9'd0, 48'h0, 27'h2000002, RUP, 32'hBF800000, 4'b0010);
    // Rounding carry-out renormalises to 2.0
    send(0, 0, 8'd127, 9'd0, 48'h0, 27'h3FFFFFE, RNE, 32'h40000000, 4'b0010);
    // Left normalise by 6 and sticky from a right normalise
    send(1, 0, 8'd0, 9'd130, 48'h010000000000, 27'h0, RNE, 32'h3E000000, 4'b0000);
    send(1, 0, 8'd0, 9'd127, 48'h800001000001, 27'h0, RNE, 32'h40000001, 4'b0010);
    send(1, 0, 8'd0, 9'd127, 48'h800001000001, 27'h0, RUP, 32'h40000002, 4'b0010);
    // Overflow in each mode
    send(1, 0, 8'd0, 9'd254, 48'h800000000000, 27'h0, RNE, 32'h7F800000, 4'b1010);
    send(1, 0, 8'd0, 9'd254, 48'h800000000000, 27'h0, RTZ, 32'h7F7FFFFF, 4'b1010);
    send(1, 1, 8'd0, 9'd254, 48'h800000000000, 27'h0, RUP, 32'hFF7FFFFF, 4'b1010);
    send(1, 1, 8'd0, 9'd254, 48'h800000000000, 27'h0, RDN, 32'hFF800000, 4'b1010);
    // Underflow flush and zero input
    send(0, 0, 8'd1, 9'd0, 48'h0, 27'h1000000, RNE, 32'h00000000, 4'b0110);
    send(1, 1, 8'd0, 9'd100, 48'h0, 27'h0, RNE, 32'h80000000, 4'b0001);
    wait_drain();

    // Backpressure: six back-to-back inputs while out_ready stays low for 5 cycles
    chk_lat   = 1'b0;
    saw_stall = 1'b0;
    out_ready = 1'b0;
    fork
      for (int k = 0; k < 6; k++)
        send(0, 0, 8'd127, 9'd0, 48'h0, 27'h2000000 | (27'(k) << 2), RNE, 32'h3F800000 + 32'(k), 4'b0000);
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain();
    chk("in_ready_dropped", 64'(saw_stall), 64'd1);
    chk_lat = 1'b1;

    // Reset with three results in flight: none of them may appear afterwards
    send(0, 0, 8'd127, 9'd0, 48'h0, 27'h2000000, RNE, 32'h3F800000, 4'b0000);
    send(1, 0, 8'd0, 9'd127, 48'h900000000000, 27'h0, RNE, 32'h40100000, 4'b0000);
    send(0, 0, 8'd127, 9'd0, 48'h0, 27'h4000000, RNE, 32'h40000000, 4'b0000);
    rst = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_result", 64'(Resultado), 64'd0);
    chk("midrst_flags", 64'({flag_ovf, flag_unf, flag_inx, flag_zero}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    repeat (10) @(posedge clk);
    #1;
    send(0, 0, 8'd127, 9'd0, 48'h0, 27'h2000008, RNE, 32'h3F800002, 4'b0000);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
